// File: rtl/instruction_issue_unit.sv
// Front-end issue stage: buffers fetched RV32I words, decodes the head entry,
// applies static branch prediction and presents one instruction per cycle to the CSU.
module instruction_issue_unit #(
  parameter int QUEUE_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_PC,
  input  logic [31:0] fetch_ins,
  input  logic        fetch_is_compressed,
  output logic        fetch_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_PC,
  input  logic        issue_space_available,
  output logic        ins_just_issued,
  output logic [31:0] issue_PC,
  output logic [31:0] issue_predicted_resulting_PC,
  output logic [31:0] ins_issued,
  output logic [6:0]  issue_opcode,
  output logic [2:0]  issue_funct3,
  output logic [6:0]  issue_funct7,
  output logic [31:0] issue_imm_val,
  output logic [5:0]  issue_shamt_val,
  output logic [4:0]  issue_rs1,
  output logic [4:0]  issue_rs2,
  output logic [4:0]  issue_rd,
  output logic        issue_is_compressed_ins
);

  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0]      pc_mem_q  [QUEUE_DEPTH];
  logic [31:0]      ins_mem_q [QUEUE_DEPTH];
  logic             cmp_mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] head_pc_s, head_ins_s, imm_s, seq_s, pred_s;
  logic        head_cmp_s, head_valid_s, pop_s, push_s, redir_s;

  assign head_pc_s    = pc_mem_q[head_q];
  assign head_ins_s   = ins_mem_q[head_q];
  assign head_cmp_s   = cmp_mem_q[head_q];
  assign head_valid_s = (count_q != {CNT_W{1'b0}});
  assign fetch_ready  = (count_q < CNT_W'(QUEUE_DEPTH));

  assign pop_s   = head_valid_s & issue_space_available & ~flush_pipline;
  assign redir_s = pop_s & (pred_s != seq_s);
  // A redirect discards everything younger, including the word fetch offers this cycle.
  assign push_s  = fetch_valid & fetch_ready & ~flush_pipline & ~redir_s;

  always_comb begin
    imm_s = 32'd0;
    case (head_ins_s[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR:
        imm_s = {{20{head_ins_s[31]}}, head_ins_s[31:20]};
      OP_STORE:
        imm_s = {{20{head_ins_s[31]}}, head_ins_s[31:25], head_ins_s[11:7]};
      OP_BRANCH:
        imm_s = {{19{head_ins_s[31]}}, head_ins_s[31], head_ins_s[7],
                 head_ins_s[30:25], head_ins_s[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_s = {head_ins_s[31:12], 12'd0};
      OP_JAL:
        imm_s = {{11{head_ins_s[31]}}, head_ins_s[31], head_ins_s[19:12],
                 head_ins_s[20], head_ins_s[30:21], 1'b0};
      default:
        imm_s = 32'd0;
    endcase
  end

  // Static prediction: JAL always taken, conditional branches taken only when backward.
  always_comb begin
    seq_s  = head_pc_s + (head_cmp_s ? 32'd2 : 32'd4);
    pred_s = seq_s;
    case (head_ins_s[6:0])
      OP_JAL:    pred_s = head_pc_s + imm_s;
      OP_BRANCH: pred_s = imm_s[31] ? (head_pc_s + imm_s) : seq_s;
      default:   pred_s = seq_s;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_pipline) begin
      tail_d  = head_q;
      count_d = {CNT_W{1'b0}};
    end else if (redir_s) begin
      head_d  = head_q + PTR_W'(1);
      tail_d  = head_q + PTR_W'(1);
      count_d = {CNT_W{1'b0}};
    end else begin
      head_d  = head_q + PTR_W'(pop_s);
      tail_d  = tail_q + PTR_W'(push_s);
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push_s) begin
      pc_mem_q[tail_q]  <= fetch_PC;
      ins_mem_q[tail_q] <= fetch_ins;
      cmp_mem_q[tail_q] <= fetch_is_compressed;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q                       <= {PTR_W{1'b0}};
      tail_q                       <= {PTR_W{1'b0}};
      count_q                      <= {CNT_W{1'b0}};
      redirect_valid               <= 1'b0;
      redirect_PC                  <= 32'd0;
      ins_just_issued              <= 1'b0;
      issue_PC                     <= 32'd0;
      issue_predicted_resulting_PC <= 32'd0;
      ins_issued                   <= 32'd0;
      issue_opcode                 <= 7'd0;
      issue_funct3                 <= 3'd0;
      issue_funct7                 <= 7'd0;
      issue_imm_val                <= 32'd0;
      issue_shamt_val              <= 6'd0;
      issue_rs1                    <= 5'd0;
      issue_rs2                    <= 5'd0;
      issue_rd                     <= 5'd0;
      issue_is_compressed_ins      <= 1'b0;
    end else if (rdy_in) begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      ins_just_issued <= pop_s;
      redirect_valid  <= redir_s;
      if (redir_s) begin
        redirect_PC <= pred_s;
      end
      if (pop_s) begin
        issue_PC                     <= head_pc_s;
        issue_predicted_resulting_PC <= pred_s;
        ins_issued                   <= head_ins_s;
        issue_opcode                 <= head_ins_s[6:0];
        issue_funct3                 <= head_ins_s[14:12];
        issue_funct7                 <= head_ins_s[31:25];
        issue_imm_val                <= imm_s;
        issue_shamt_val              <= head_ins_s[25:20];
        issue_rs1                    <= head_ins_s[19:15];
        issue_rs2                    <= head_ins_s[24:20];
        issue_rd                     <= head_ins_s[11:7];
        issue_is_compressed_ins      <= head_cmp_s;
      end
    end
  end

endmodule

// File: tb/tb_instruction_issue_unit.sv
// Self-checking bench for instruction_issue_unit: directed scenarios followed by
// random traffic, all compared cycle by cycle against a queue-based reference model.
module tb_instruction_issue_unit;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_pipline, fetch_valid, fetch_is_compressed;
  logic [31:0] fetch_PC, fetch_ins;
  logic        issue_space_available;
  logic        fetch_ready, redirect_valid, ins_just_issued, issue_is_compressed_ins;
  logic [31:0] redirect_PC, issue_PC, issue_predicted_resulting_PC, ins_issued, issue_imm_val;
  logic [6:0]  issue_opcode, issue_funct7;
  logic [2:0]  issue_funct3;
  logic [5:0]  issue_shamt_val;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;

  instruction_issue_unit #(.QUEUE_DEPTH(4), .PTR_W(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .fetch_valid(fetch_valid), .fetch_PC(fetch_PC), .fetch_ins(fetch_ins),
    .fetch_is_compressed(fetch_is_compressed), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_PC(redirect_PC),
    .issue_space_available(issue_space_available), .ins_just_issued(ins_just_issued),
    .issue_PC(issue_PC), .issue_predicted_resulting_PC(issue_predicted_resulting_PC),
    .ins_issued(ins_issued), .issue_opcode(issue_opcode), .issue_funct3(issue_funct3),
    .issue_funct7(issue_funct7), .issue_imm_val(issue_imm_val),
    .issue_shamt_val(issue_shamt_val), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_is_compressed_ins(issue_is_compressed_ins)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        cmp;
  } entry_t;

  entry_t      mq[$];
  int          checks = 0;
  int          errors = 0;
  logic        armed  = 1'b0;
  logic        e_iji, e_rv, e_cmp, last_push;
  logic [31:0] e_rpc, e_pc, e_pred, e_ins, e_imm;

  localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;
  localparam logic [31:0] BEQ_M8    = 32'hFE00_0CE3;
  localparam logic [31:0] CBEQZ_P8  = 32'h0004_0463;

  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int v;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: v = int'($signed(w[31:20]));
      7'h23: v = int'($signed({w[31:25], w[11:7]}));
      7'h63: v = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      7'h37, 7'h17: v = int'(w & 32'hFFFF_F000);
      7'h6F: v = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_pred(input logic [31:0] pc, input logic [31:0] w,
                                           input logic cmp);
    logic [31:0] imm;
    imm = ref_imm(w);
    if (w[6:0] == 7'h6F) return pc + imm;
    if (w[6:0] == 7'h63 && $signed(imm) < 0) return pc + imm;
    return pc + (cmp ? 32'd2 : 32'd4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: advances one clock edge using the inputs currently driven.
  task automatic model_edge();
    entry_t      h;
    logic        ready, redirected;
    logic [31:0] seq;
    last_push = 1'b0;
    if (rst_in) begin
      mq.delete();
      e_iji = 1'b0; e_rv = 1'b0; e_cmp = 1'b0;
      e_rpc = 32'd0; e_pc = 32'd0; e_pred = 32'd0; e_ins = 32'd0; e_imm = 32'd0;
      armed = 1'b1;
      return;
    end
    if (!rdy_in) return;
    if (flush_pipline) begin
      mq.delete();
      e_iji = 1'b0; e_rv = 1'b0;
      return;
    end
    ready      = (mq.size() < 4);
    redirected = 1'b0;
    e_iji = 1'b0; e_rv = 1'b0;
    if (mq.size() > 0 && issue_space_available) begin
      h      = mq.pop_front();
      seq    = h.pc + (h.cmp ? 32'd2 : 32'd4);
      e_pc   = h.pc; e_ins = h.ins; e_cmp = h.cmp;
      e_imm  = ref_imm(h.ins);
      e_pred = ref_pred(h.pc, h.ins, h.cmp);
      e_iji  = 1'b1;
      if (e_pred != seq) begin
        e_rv = 1'b1; e_rpc = e_pred; redirected = 1'b1;
        mq.delete();
      end
    end
    if (fetch_valid && ready && !redirected) begin
      mq.push_back('{pc: fetch_PC, ins: fetch_ins, cmp: fetch_is_compressed});
      last_push = 1'b1;
    end
  endtask

  task automatic check_outputs();
    chk("ins_just_issued", 32'(ins_just_issued), 32'(e_iji));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("redirect_PC", redirect_PC, e_rpc);
    chk("issue_PC", issue_PC, e_pc);
    chk("predicted_PC", issue_predicted_resulting_PC, e_pred);
    chk("ins_issued", ins_issued, e_ins);
    chk("opcode", 32'(issue_opcode), 32'(e_ins[6:0]));
    chk("funct3", 32'(issue_funct3), 32'(e_ins[14:12]));
    chk("funct7", 32'(issue_funct7), 32'(e_ins[31:25]));
    chk("imm_val", issue_imm_val, e_imm);
    chk("shamt", 32'(issue_shamt_val), 32'(e_ins[25:20]));
    chk("rs1", 32'(issue_rs1), 32'(e_ins[19:15]));
    chk("rs2", 32'(issue_rs2), 32'(e_ins[24:20]));
    chk("rd", 32'(issue_rd), 32'(e_ins[11:7]));
    chk("compressed", 32'(issue_is_compressed_ins), 32'(e_cmp));
  endtask

  task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic cmp, input logic space, input logic flush, input logic rdy);
    fetch_valid = fv; fetch_PC = pc; fetch_ins = ins; fetch_is_compressed = cmp;
    issue_space_available = space; flush_pipline = flush; rdy_in = rdy;
    #1;
    if (armed) chk("fetch_ready", 32'(fetch_ready), 32'(mq.size() < 4));
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    logic [31:0] w;
    w      = $urandom;
    w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] got[$];
    logic        pend;
    logic [31:0] rpc, rins, npc;
    logic        rfv, rcmp;

    rst_in = 1'b1; rdy_in = 1'b0; flush_pipline = 1'b0; fetch_valid = 1'b0;
    fetch_PC = 32'd0; fetch_ins = 32'd0; fetch_is_compressed = 1'b0;
    issue_space_available = 1'b0;
    @(negedge clk_in);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("reset_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("reset_iji", 32'(ins_just_issued), 32'd0);
    chk("reset_issue_PC", issue_PC, 32'd0);
    rst_in = 1'b0;

    // ADDI x1,x0,5 at PC 0: pulse two cycles after the push edge
    step(1'b1, 32'h0, ADDI_X1_5, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("addi_not_yet", 32'(ins_just_issued), 32'd0);
    step(1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("addi_iji", 32'(ins_just_issued), 32'd1);
    chk("addi_rd", 32'(issue_rd), 32'd1);
    chk("addi_imm", issue_imm_val, 32'd5);
    chk("addi_pred", issue_predicted_resulting_PC, 32'h4);
    step(1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("addi_single_pulse", 32'(ins_just_issued), 32'd0);

    // Backpressure: four accepted, fifth waits until space frees
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(i * 4), 32'h0000_0013 | 32'(i << 7), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_full_ready", 32'(fetch_ready), 32'd0);
    pend = 1'b1;
    got.delete();
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      step(pend, 32'h10, 32'h0000_0213, 1'b0, 1'b1, 1'b0, 1'b1);
      if (last_push) pend = 1'b0;
      if (ins_just_issued) got.push_back(issue_PC);
    end
    chk("bp_issue_count", 32'(got.size()), 32'd5);
    for (int k = 0; k < 5 && k < got.size(); k++) chk("bp_order", got[k], 32'(k * 4));

    // Backward BEQ with two younger entries queued behind it
    step(1'b1, 32'h100, BEQ_M8, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h104, ADDI_X1_5, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h108, ADDI_X1_5, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h10C, ADDI_X1_5, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("beq_redirect", 32'(redirect_valid), 32'd1);
    chk("beq_redirect_PC", redirect_PC, 32'hF8);
    chk("beq_pred", issue_predicted_resulting_PC, 32'hF8);
    chk("beq_issue_PC", issue_PC, 32'h100);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("beq_younger_dropped", 32'(ins_just_issued), 32'd0);
    end
    chk("beq_redirect_pulse_end", 32'(redirect_valid), 32'd0);

    // Compressed forward branch: not taken, sequential +2
    step(1'b1, 32'h20, CBEQZ_P8, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("cbr_iji", 32'(ins_just_issued), 32'd1);
    chk("cbr_pred", issue_predicted_resulting_PC, 32'h22);
    chk("cbr_no_redirect", 32'(redirect_valid), 32'd0);
    chk("cbr_compressed", 32'(issue_is_compressed_ins), 32'd1);

    // Flush with three queued entries and a concurrent push
    step(1'b1, 32'h40, ADDI_X1_5, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h44, ADDI_X1_5, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h48, ADDI_X1_5, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h4C, ADDI_X1_5, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("flush_iji", 32'(ins_just_issued), 32'd0);
    chk("flush_ready", 32'(fetch_ready), 32'd1);
    step(1'b1, 32'h200, ADDI_X1_5, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush_empty_no_issue", 32'(ins_just_issued), 32'd0);
    step(1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("post_flush_issue", issue_PC, 32'h200);
    chk("post_flush_iji", 32'(ins_just_issued), 32'd1);

    // rdy_in low for three cycles mid-stream
    step(1'b1, 32'h300, ADDI_X1_5, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h304, ADDI_X1_5, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h308, ADDI_X1_5, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rdy_first_issue", issue_PC, 32'h300);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 32'h30C, ADDI_X1_5, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("rdy_frozen_PC", issue_PC, 32'h300);
    end
    got.delete();
    for (int c = 0; c < 10 && got.size() < 2; c++) begin
      step(1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      if (ins_just_issued) got.push_back(issue_PC);
    end
    chk("rdy_resume_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("rdy_resume_0", got[0], 32'h304);
      chk("rdy_resume_1", got[1], 32'h308);
    end

    // Random traffic against the model
    rfv = 1'b0; rpc = 32'h1000; rins = 32'd0; rcmp = 1'b0; npc = 32'h1000;
    for (int c = 0; c < 600; c++) begin
      if (!rfv || last_push) begin
        rfv  = ($urandom_range(0, 9) < 7);
        rpc  = npc;
        rins = rand_ins();
        rcmp = ($urandom_range(0, 3) == 0);
        npc  = rpc + (rcmp ? 32'd2 : 32'd4);
      end
      step(rfv, rpc, rins, rcmp, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) != 0));
      if (e_rv) npc = e_rpc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_issue_unit.md
Name: instruction_issue_unit

Overview:
- Front-end issue stage: buffers instruction words from fetch, decodes RV32I fields, applies static branch prediction, and presents one instruction per cycle to the central schedule unit's issue interface.
- Drives the CSU issue bundle (ins_just_issued, issue_PC, decoded fields) and honours issue_space_available.
- Squashes everything on flush_pipline.
- Sends taken-prediction redirects back to fetch.

Parameters:
- QUEUE_DEPTH, 4, instruction buffer entries (power of two, ≥2).
- PTR_W, 2, log2(QUEUE_DEPTH).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; all state frozen when low
- flush_pipline  input  1  CSU misprediction flush
- fetch_valid  input  1  fetch presents an instruction
- fetch_PC  input  32  PC of presented instruction
- fetch_ins  input  32  instruction word (compressed forms arrive pre-expanded)
- fetch_is_compressed  input  1  original instruction was 16-bit
- fetch_ready  output  1  buffer can accept this cycle
- redirect_valid  output  1  one-cycle pulse: fetch must restart at redirect_PC
- redirect_PC  output  32  predicted target
- issue_space_available  input  1  CSU has a free slot
- ins_just_issued  output  1  one-cycle pulse: issue bundle valid
- issue_PC  output  32  PC
- issue_predicted_resulting_PC  output  32  predicted next PC
- ins_issued  output  32  raw word
- issue_opcode  output  7  ins[6:0]
- issue_funct3  output  3  ins[14:12]
- issue_funct7  output  7  ins[31:25]
- issue_imm_val  output  32  sign-extended immediate
- issue_shamt_val  output  6  ins[25:20]
- issue_rs1  output  5  ins[19:15]
- issue_rs2  output  5  ins[24:20]
- issue_rd  output  5  ins[11:7]
- issue_is_compressed_ins  output  1  compressed flag

Behaviour:
- Reset (rst_in=1 at posedge, overrides rdy_in): head=tail=0, count=0; all outputs 0 except fetch_ready=1.
- rdy_in=0: no state change; registered outputs hold; pulses do not repeat.
- Buffer:
  - Circular queue of {PC, word, compressed}, pointers PTR_W bits, wrapping naturally.
  - fetch_ready = (count < QUEUE_DEPTH), combinational from count.
  - Push when fetch_valid & fetch_ready.
  - Pop when head valid & issue_space_available & !flush_pipline.
  - Simultaneous push and pop allowed at any count, including full→pop+push-blocked (fetch_ready low when full) and empty (a push cannot be popped in the same cycle).
- Decode (combinational on head entry):
  - I-type (0000011, 0010011, 1100111): imm = sext(ins[31:20]).
  - S-type: imm = sext({ins[31:25], ins[11:7]}).
  - B-type: imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}).
  - U-type: imm = {ins[31:12], 12'b0}.
  - J-type: imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}).
  - Otherwise imm = 0.
  - Fields are always extracted raw, regardless of format.
- Prediction (32-bit wrap arithmetic):
  - seq = PC + (compressed ? 2 : 4).
  - JAL: PC+imm.
  - Branch: PC+imm if imm[31]=1 (backward taken), else seq.
  - JALR and all others: seq.
- Issue timing:
  - Pop at edge N loads all issue_* registers and sets ins_just_issued=1 during cycle N+1; ins_just_issued clears at the next edge unless another pop occurs.
  - Minimum latency from push at edge N to ins_just_issued: high in cycle N+2.
  - Issue fields hold their last values when not pulsing.
- Redirect:
  - If the popped instruction predicts non-seq, at the same edge: redirect_valid=1 for one cycle, redirect_PC=target.
  - All younger buffer entries are discarded (tail=head+1 after pop, count=0).
  - A push in that same cycle is dropped.
- Flush:
  - flush_pipline=1 at an edge: queue emptied, no pop, push dropped.
  - ins_just_issued=0 and redirect_valid=0 next cycle.
  - Flush has priority over pop, push and redirect; reset has priority over flush.
- Backpressure: issue_space_available=0 holds head; a full buffer deasserts fetch_ready; no entry is lost or duplicated.

Test Plan:
- Reset, then push ADDI x1,x0,5 (0x00500093) at PC 0x0 → two cycles later ins_just_issued=1 for exactly one cycle, issue_rd=1, issue_imm_val=5, issue_predicted_resulting_PC=0x4.
- Backpressure: issue_space_available=0, push 5 words → fetch_ready=0 after 4 accepted; raise space → 4 pulses in PC order 0x0,0x4,0x8,0xC; the 5th word is accepted once space frees.
- Backward BEQ at PC 0x100 with imm=-8, two younger entries queued → redirect_valid=1, redirect_PC=0xF8, predicted PC 0xF8; younger entries are never issued.
- Compressed forward branch at PC 0x20, fetch_is_compressed=1 → predicted 0x22, no redirect, issue_is_compressed_ins=1.
- flush_pipline asserted with 3 queued entries and a concurrent push → next cycle ins_just_issued=0, fetch_ready=1, count=0; subsequent push at 0x200 issues normally.
- rdy_in=0 for 3 cycles mid-stream → outputs frozen, no duplicate ins_just_issued pulse; issue resumes in order when rdy_in returns high.
